// File: rtl/timer_pkg.sv
// Shared constants for the MM:SS timer slice.
package timer_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int SEC_LIMIT_DEF    = 60;
    localparam int MIN_LIMIT_DEF    = 60;
endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps to 00 after LIMIT-1.
module bcd_pair_counter
    import timer_pkg::*;
#(
    parameter int LIMIT = SEC_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry
);
    localparam int MAXV = LIMIT - 1;
    localparam logic [3:0] MAX_ONES = 4'(MAXV % 10);
    localparam logic [3:0] MAX_TENS = 4'(MAXV / 10);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       at_max;

    assign at_max = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);
    assign carry  = inc & at_max;
    assign ones   = ones_q;
    assign tens   = tens_q;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr || (inc && at_max)) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc) begin
            if (ones_q == BCD_MAX) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end
endmodule

// File: rtl/minute_second_counter.sv
// MM:SS BCD stopwatch driven by rising edges of newclock.
module minute_second_counter
    import timer_pkg::*;
#(
    parameter int MINUTE_LIMIT = MIN_LIMIT_DEF,
    parameter int SECOND_LIMIT = SEC_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       newclock,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);
    logic [1:0] state_q, state_d;
    logic       nclk_q;
    logic       running_q;
    logic       rollover_q;
    logic       tick;
    logic       count_en;
    logic       sec_carry;
    logic       min_carry;

    assign tick     = newclock & ~nclk_q;
    assign count_en = tick & (state_q == ST_RUN) & ~clear & ~stop;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (start) begin
            state_d = ST_RUN;
        end
    end

    // Edge register resets high so a newclock already high at release is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            nclk_q     <= 1'b1;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nclk_q     <= newclock;
            running_q  <= (state_d == ST_RUN);
            rollover_q <= min_carry;
        end
    end

    bcd_pair_counter #(.LIMIT(SECOND_LIMIT)) u_sec (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (count_en),
        .ones  (sec_ones),
        .tens  (sec_tens),
        .carry (sec_carry)
    );

    bcd_pair_counter #(.LIMIT(MINUTE_LIMIT)) u_min (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sec_carry),
        .ones  (min_ones),
        .tens  (min_tens),
        .carry (min_carry)
    );

    assign running  = running_q;
    assign rollover = rollover_q;
endmodule

// File: tb/tb_minute_second_counter.sv
// Scoreboard bench: elapsed-seconds model vs. BCD MM:SS outputs.
module tb_minute_second_counter;
    localparam int ML = 60;
    localparam int SL = 60;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic newclock = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic running, rollover;

    int n_tests = 0;
    int n_fail = 0;

    logic [17:0] exp_q[$];

    // model state: 0 idle, 1 run, 2 pause
    int m_state = 0;
    int m_total = 0;
    bit m_prev = 1'b1;
    bit m_roll = 1'b0;

    minute_second_counter dut (
        .clk      (clk),
        .reset    (reset),
        .newclock (newclock),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .rollover (rollover)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pack_exp();
        int s, m;
        s = m_total % SL;
        m = m_total / SL;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                (m_state == 1), m_roll};
    endfunction

    function automatic logic [17:0] pack_dut();
        return {min_tens, min_ones, sec_tens, sec_ones, running, rollover};
    endfunction

    task automatic model_step(input bit r, input bit nc, input bit st,
                              input bit sp, input bit cl);
        bit t;
        if (!r) begin
            m_state = 0;
            m_total = 0;
            m_prev  = 1'b1;
            m_roll  = 1'b0;
        end else begin
            t = nc && !m_prev;
            m_prev = nc;
            m_roll = 1'b0;
            if (cl) begin
                m_total = 0;
                m_state = 0;
            end else if (sp) begin
                if (m_state == 1) m_state = 2;
            end else begin
                if (m_state == 1 && t) begin
                    m_total = m_total + 1;
                    if (m_total == ML * SL) begin
                        m_total = 0;
                        m_roll  = 1'b1;
                    end
                end
                if (st) m_state = 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit nc, input bit st,
                       input bit sp, input bit cl);
        @(negedge clk);
        reset    = r;
        newclock = nc;
        start    = st;
        stop     = sp;
        clear    = cl;
        model_step(r, nc, st, sp, cl);
        exp_q.push_back(pack_exp());
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 1, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
        end
    endtask

    task automatic chk(input string name, input logic [17:0] act,
                       input logic [17:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // monitor: one expected entry per clock
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            e = exp_q.pop_front();
            chk("scoreboard", pack_dut(), e);
        end
    end

    initial begin
        // 1: reset held with newclock high, then release
        #1;
        chk("reset_state", pack_dut(), 18'h0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        settle();
        chk("no_spurious_tick", pack_dut(), 18'h0);

        // 2: basic count of 12
        cyc(1, 0, 1, 0, 0);
        tick_n(11);
        cyc(1, 1, 0, 0, 0);
        settle();
        chk("count_12", pack_dut(), {16'h0012, 1'b1, 1'b0});
        cyc(1, 0, 0, 0, 0);

        // 3: minute carry 00:59 -> 01:00
        tick_n(47);
        settle();
        chk("at_00_59", pack_dut(), {16'h0059, 1'b1, 1'b0});
        tick_n(1);
        settle();
        chk("minute_carry", pack_dut(), {16'h0100, 1'b1, 1'b0});

        // 4: full wrap 59:59 -> 00:00
        tick_n(3539);
        settle();
        chk("at_59_59", pack_dut(), {16'h5959, 1'b1, 1'b0});
        cyc(1, 1, 0, 0, 0);
        settle();
        chk("wrap_pulse", pack_dut(), {16'h0000, 1'b1, 1'b1});
        cyc(1, 0, 0, 0, 0);
        settle();
        chk("wrap_pulse_end", pack_dut(), {16'h0000, 1'b1, 1'b0});

        // 5: pause and precedence
        tick_n(5);
        cyc(1, 0, 1, 1, 0);
        settle();
        chk("stop_wins", pack_dut(), {16'h0005, 1'b0, 1'b0});
        tick_n(3);
        settle();
        chk("paused_hold", pack_dut(), {16'h0005, 1'b0, 1'b0});
        cyc(1, 0, 1, 0, 0);
        tick_n(1);
        settle();
        chk("resume", pack_dut(), {16'h0006, 1'b1, 1'b0});

        // 6: clear beats tick, then async reset mid-run
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0);
        tick_n(207);
        settle();
        chk("at_03_27", pack_dut(), {16'h0327, 1'b1, 1'b0});
        cyc(1, 1, 0, 0, 1);
        settle();
        chk("clear_vs_tick", pack_dut(), 18'h0);
        cyc(1, 0, 1, 0, 0);
        tick_n(4);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", pack_dut(), 18'h0);
        model_step(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 23) == 0),
                ($urandom_range(0, 99) == 0));
        end

        settle();
        settle();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
